// File: rtl/codec_cfg_sequencer_if.sv
// Shifter-facing bus of codec_cfg_sequencer: word handshake, 24-bit word and I2C phase enables.
interface codec_cfg_sequencer_if;
    logic        NEXT_WORD;
    logic        ACK_ERR;
    logic [23:0] DATA;
    logic        TRANSACTION_REQ;
    logic        CLOCK_500;
    logic        CLOCK_500_ena;
    logic        CLOCK_SDAT_ena;

    modport master (
        input  NEXT_WORD, ACK_ERR,
        output DATA, TRANSACTION_REQ, CLOCK_500, CLOCK_500_ena, CLOCK_SDAT_ena
    );

    modport slave (
        output NEXT_WORD, ACK_ERR,
        input  DATA, TRANSACTION_REQ, CLOCK_500, CLOCK_500_ena, CLOCK_SDAT_ena
    );
endinterface

// File: rtl/codec_cfg_sequencer.sv
// Audio codec configuration sequencer: I2C phase generator plus register-write table walker.
// Optional NACK retry enabled by defining CODEC_CFG_RETRY_EN.
module codec_cfg_sequencer #(
    parameter int         CLK_DIV      = 2048,
    parameter int         SCL_HI_START = 800,
    parameter int         SCL_HI_END   = 1820,
    parameter int         SDA_START    = 450,
    parameter int         SDA_END      = 1990,
    parameter int         N_WORDS      = 11,
    parameter logic [7:0] SLAVE_ADDR   = 8'h34,
    parameter int         MAX_RETRY    = 3
) (
    input  logic                         CLOCK31_5,
    input  logic                         rst_n,
    codec_cfg_sequencer_if.master        bus,
    input  logic                         KEY0_EDGE,
    input  logic                         MICROPHON_ON,
    output logic                         CFG_DONE,
    output logic                         CFG_ERR,
    output logic [3:0]                   WORD_IDX
);
    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    generate
        if (!(SCL_HI_START < SCL_HI_END && SCL_HI_END <= CLK_DIV)) begin : g_bad_scl
            $fatal(1, "codec_cfg_sequencer: SCL window must satisfy START < END <= CLK_DIV");
        end
        if (!(SDA_START < SDA_END && SDA_END <= CLK_DIV)) begin : g_bad_sda
            $fatal(1, "codec_cfg_sequencer: SDA window must satisfy START < END <= CLK_DIV");
        end
        if (N_WORDS < 2 || N_WORDS > 11) begin : g_bad_nwords
            $fatal(1, "codec_cfg_sequencer: N_WORDS must be in 2..11");
        end
    endgenerate

    typedef enum logic [1:0] {S_RUN, S_DONE, S_ERROR} state_t;

    logic [CNT_W-1:0] r_cnt;
    logic             r_clk500, r_clk500_d;
    logic             r_sdat, r_sdat_d, r_sdat_ena;
    logic             r_sync1, r_sync2;
    logic             r_mic_cfg, w_mic_cfg_nxt;
    state_t           r_state, w_state_nxt;
    logic [3:0]       r_idx, w_idx_nxt;
    logic [RTY_W-1:0] r_retry, w_retry_nxt;
    logic             w_restart;

    function automatic logic [15:0] tbl_word(input logic [3:0] idx, input logic mic);
        logic [15:0] w;
        case (idx)
            4'd0:    w = 16'h1200;
            4'd1:    w = 16'h0C00;
            4'd2:    w = 16'h0E42;
            4'd3:    w = mic ? 16'h0814 : 16'h0810;
            4'd4:    w = 16'h107C;
            4'd5:    w = 16'h007F;
            4'd6:    w = 16'h027F;
            4'd7:    w = 16'h047F;
            4'd8:    w = 16'h067F;
            4'd9:    w = 16'h0A01;
            default: w = 16'h1201;
        endcase
        // The activate word always closes the table, whatever its length.
        if (idx == 4'(N_WORDS - 1)) w = 16'h1201;
        return w;
    endfunction

    always_ff @(posedge CLOCK31_5 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_clk500   <= 1'b0;
            r_clk500_d <= 1'b0;
            r_sdat     <= 1'b0;
            r_sdat_d   <= 1'b0;
            r_sdat_ena <= 1'b0;
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
        end else begin
            r_cnt      <= (r_cnt == CNT_W'(CLK_DIV - 1)) ? '0 : r_cnt + CNT_W'(1);
            r_clk500   <= (r_cnt >= CNT_W'(SCL_HI_START)) && (r_cnt < CNT_W'(SCL_HI_END));
            r_clk500_d <= r_clk500;
            r_sdat     <= (r_cnt >= CNT_W'(SDA_START)) && (r_cnt < CNT_W'(SDA_END));
            r_sdat_d   <= r_sdat;
            r_sdat_ena <= r_sdat & ~r_sdat_d;
            r_sync1    <= MICROPHON_ON;
            r_sync2    <= r_sync1;
        end
    end

    always_ff @(posedge CLOCK31_5 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RUN;
            r_idx     <= '0;
            r_retry   <= '0;
            r_mic_cfg <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_retry   <= w_retry_nxt;
            r_mic_cfg <= w_mic_cfg_nxt;
        end
    end

    assign w_restart = KEY0_EDGE | (r_sync2 != r_mic_cfg);

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_retry_nxt   = r_retry;
        w_mic_cfg_nxt = r_mic_cfg;
        if (w_restart) begin
            w_state_nxt   = S_RUN;
            w_idx_nxt     = '0;
            w_retry_nxt   = '0;
            w_mic_cfg_nxt = r_sync2;
        end else if (r_state == S_RUN && bus.NEXT_WORD) begin
`ifdef CODEC_CFG_RETRY_EN
            if (bus.ACK_ERR) begin
                if (r_retry == RTY_W'(MAX_RETRY)) w_state_nxt = S_ERROR;
                else                               w_retry_nxt = r_retry + RTY_W'(1);
            end else
`endif
            begin
                w_retry_nxt = '0;
                // idx parks on the activate word so DONE keeps presenting it.
                if (r_idx == 4'(N_WORDS - 1)) w_state_nxt = S_DONE;
                else                          w_idx_nxt   = r_idx + 4'd1;
            end
        end
    end

    assign bus.DATA            = {SLAVE_ADDR, tbl_word(r_idx, r_mic_cfg)};
    assign bus.TRANSACTION_REQ = (r_state == S_RUN);
    assign bus.CLOCK_500       = r_clk500;
    assign bus.CLOCK_500_ena   = r_clk500 & ~r_clk500_d;
    assign bus.CLOCK_SDAT_ena  = r_sdat_ena;
    assign CFG_DONE            = (r_state == S_DONE);
`ifdef CODEC_CFG_RETRY_EN
    assign CFG_ERR             = (r_state == S_ERROR);
`else
    assign CFG_ERR             = 1'b0;
`endif
    assign WORD_IDX            = r_idx;
endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Scoreboard bench for codec_cfg_sequencer: default table (u_a) and a 4-word table (u_b).
`timescale 1ns/1ps
module tb_codec_cfg_sequencer;
    logic clk;
    logic rst_n, key, mic;
    logic done_a, err_a, done_b, err_b;
    logic [3:0] idx_a, idx_b;

    codec_cfg_sequencer_if bus_a ();
    codec_cfg_sequencer_if bus_b ();

    codec_cfg_sequencer u_a (
        .CLOCK31_5(clk), .rst_n(rst_n), .bus(bus_a), .KEY0_EDGE(key), .MICROPHON_ON(mic),
        .CFG_DONE(done_a), .CFG_ERR(err_a), .WORD_IDX(idx_a)
    );

    codec_cfg_sequencer #(.N_WORDS(4)) u_b (
        .CLOCK31_5(clk), .rst_n(rst_n), .bus(bus_b), .KEY0_EDGE(key), .MICROPHON_ON(mic),
        .CFG_DONE(done_b), .CFG_ERR(err_b), .WORD_IDX(idx_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // kind 0: status of dut (0=u_a, 1=u_b); kind 1: phase counts; kind 2: phase outputs of u_a
    typedef struct {
        int unsigned at;
        int          kind;
        int          dut;
        string       name;
        logic [23:0] data;
        logic [3:0]  idx;
        logic        done, err, req;
        logic        c5, c5e, sde;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned pc;
    logic        meas_on = 1'b0;
    int          m_hi = 0, m_n5 = 0, m_nsd = 0, m_wide = 0;

    logic [23:0] seq_l [11] = '{24'h341200, 24'h340C00, 24'h340E42, 24'h340810, 24'h34107C,
                                24'h34007F, 24'h34027F, 24'h34047F, 24'h34067F, 24'h340A01, 24'h341201};
    logic [23:0] seq_m [11] = '{24'h341200, 24'h340C00, 24'h340E42, 24'h340814, 24'h34107C,
                                24'h34007F, 24'h34027F, 24'h34047F, 24'h34067F, 24'h340A01, 24'h341201};
    logic [23:0] seq_b [4]  = '{24'h341200, 24'h340C00, 24'h340E42, 24'h341201};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 0;
        else        pc <= pc + 1;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, pc);
        end
    endfunction

    task automatic push_st(input int unsigned at, input int dut, input string name,
                           input logic [23:0] d, input logic [3:0] i,
                           input logic dn, input logic er, input logic rq);
        exp_t e;
        e.at = at; e.kind = 0; e.dut = dut; e.name = name;
        e.data = d; e.idx = i; e.done = dn; e.err = er; e.req = rq;
        e.c5 = 1'b0; e.c5e = 1'b0; e.sde = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_ph(input int unsigned at, input int kind, input string name,
                           input logic c5, input logic c5e, input logic sde);
        exp_t e;
        e.at = at; e.kind = kind; e.dut = 0; e.name = name;
        e.data = '0; e.idx = '0; e.done = 1'b0; e.err = 1'b0; e.req = 1'b0;
        e.c5 = c5; e.c5e = c5e; e.sde = sde;
        exp_q.push_back(e);
    endtask

    // Monitor: accumulate phase statistics and retire every expectation due this cycle.
    initial begin
        exp_t e;
        logic p5, psd;
        p5 = 1'b0; psd = 1'b0;
        forever begin
            @(negedge clk);
            if (meas_on) begin
                if (bus_a.CLOCK_500) m_hi++;
                if (bus_a.CLOCK_500_ena) begin m_n5++; if (p5) m_wide++; end
                if (bus_a.CLOCK_SDAT_ena) begin m_nsd++; if (psd) m_wide++; end
            end
            p5  = bus_a.CLOCK_500_ena;
            psd = bus_a.CLOCK_SDAT_ena;
            while (exp_q.size() > 0 && exp_q[0].at <= pc) begin
                e = exp_q.pop_front();
                if (e.at < pc) chk({e.name, "/late"}, pc, e.at);
                else if (e.kind == 0 && e.dut == 0) begin
                    chk({e.name, "/DATA"}, bus_a.DATA, e.data);
                    chk({e.name, "/IDX"}, idx_a, e.idx);
                    chk({e.name, "/DONE"}, done_a, e.done);
                    chk({e.name, "/ERR"}, err_a, e.err);
                    chk({e.name, "/REQ"}, bus_a.TRANSACTION_REQ, e.req);
                end else if (e.kind == 0) begin
                    chk({e.name, "/DATA"}, bus_b.DATA, e.data);
                    chk({e.name, "/IDX"}, idx_b, e.idx);
                    chk({e.name, "/DONE"}, done_b, e.done);
                    chk({e.name, "/ERR"}, err_b, e.err);
                    chk({e.name, "/REQ"}, bus_b.TRANSACTION_REQ, e.req);
                end else if (e.kind == 1) begin
                    chk({e.name, "/scl_high"}, m_hi, 2040);
                    chk({e.name, "/scl_ena_cnt"}, m_n5, 2);
                    chk({e.name, "/sda_ena_cnt"}, m_nsd, 2);
                    chk({e.name, "/ena_width"}, m_wide, 0);
                end else begin
                    chk({e.name, "/CLOCK_500"}, bus_a.CLOCK_500, e.c5);
                    chk({e.name, "/CLOCK_500_ena"}, bus_a.CLOCK_500_ena, e.c5e);
                    chk({e.name, "/CLOCK_SDAT_ena"}, bus_a.CLOCK_SDAT_ena, e.sde);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic ack);
        bus_a.ACK_ERR   = ack;
        bus_a.NEXT_WORD = 1'b1;
        step();
        bus_a.NEXT_WORD = 1'b0;
        bus_a.ACK_ERR   = 1'b0;
    endtask

    task automatic pulse_b();
        bus_b.NEXT_WORD = 1'b1;
        step();
        bus_b.NEXT_WORD = 1'b0;
    endtask

    initial begin
        #500000;
        bad++;
        $display("FAIL watchdog: got timeout at cycle %0d, expected completion", pc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int unsigned c0;
        rst_n = 1'b0; key = 1'b0; mic = 1'b0;
        bus_a.NEXT_WORD = 1'b0; bus_a.ACK_ERR = 1'b0;
        bus_b.NEXT_WORD = 1'b0; bus_b.ACK_ERR = 1'b0;
        repeat (3) @(posedge clk);
        push_st(0, 0, "rst_a", 24'h341200, 4'd0, 1'b0, 1'b0, 1'b1);
        push_st(0, 1, "rst_b", 24'h341200, 4'd0, 1'b0, 1'b0, 1'b1);
        push_ph(0, 2, "rst_ph", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();

        // Full 11-word walk on the default table, then an ignored pulse in DONE.
        for (int k = 0; k < 11; k++) begin
            if (k < 10) push_st(pc + 1, 0, $sformatf("seq_a%0d", k), seq_l[k+1], 4'(k + 1), 1'b0, 1'b0, 1'b1);
            else        push_st(pc + 1, 0, "seq_a_done", 24'h341201, 4'd10, 1'b1, 1'b0, 1'b0);
            pulse_a(1'b0);
        end
        push_st(pc + 1, 0, "done_hold", 24'h341201, 4'd10, 1'b1, 1'b0, 1'b0);
        pulse_a(1'b0);

        // Shortened 4-word table.
        for (int k = 0; k < 4; k++) begin
            if (k < 3) push_st(pc + 1, 1, $sformatf("seq_b%0d", k), seq_b[k+1], 4'(k + 1), 1'b0, 1'b0, 1'b1);
            else       push_st(pc + 1, 1, "seq_b_done", 24'h341201, 4'd3, 1'b1, 1'b0, 1'b0);
            pulse_b();
        end

        // Phase edges relative to reset release (cnt equals cycles since release).
        while (pc < 449) step();
        push_ph(451, 2, "sda451", 1'b0, 1'b0, 1'b0);
        push_ph(452, 2, "sda452", 1'b0, 1'b0, 1'b1);
        push_ph(453, 2, "sda453", 1'b0, 1'b0, 1'b0);
        while (pc < 799) step();
        push_ph(800, 2, "scl800", 1'b0, 1'b0, 1'b0);
        push_ph(801, 2, "scl801", 1'b1, 1'b1, 1'b0);
        push_ph(802, 2, "scl802", 1'b1, 1'b0, 1'b0);
        while (pc < 1819) step();
        push_ph(1820, 2, "scl1820", 1'b1, 1'b0, 1'b0);
        push_ph(1821, 2, "scl1821", 1'b0, 1'b0, 1'b0);

        // Two full periods of free-running phase generator.
        while (pc < 1830) step();
        meas_on = 1'b1;
        repeat (4096) step();
        meas_on = 1'b0;
        push_ph(pc, 1, "freerun", 1'b0, 1'b0, 1'b0);
        step();

        // Mode change from DONE: restart lands three cycles after the switch moves.
        c0 = pc;
        mic = 1'b1;
        push_st(c0 + 2, 0, "mic_wait", 24'h341201, 4'd10, 1'b1, 1'b0, 1'b0);
        push_st(c0 + 3, 0, "mic_rst_a", 24'h341200, 4'd0, 1'b0, 1'b0, 1'b1);
        push_st(c0 + 3, 1, "mic_rst_b", 24'h341200, 4'd0, 1'b0, 1'b0, 1'b1);
        repeat (3) step();
        for (int k = 0; k < 4; k++) begin
            push_st(pc + 1, 0, $sformatf("mic_seq%0d", k), seq_m[k+1], 4'(k + 1), 1'b0, 1'b0, 1'b1);
            pulse_a(1'b0);
        end

        // NACK on word 4.
`ifdef CODEC_CFG_RETRY_EN
        for (int k = 0; k < 3; k++) begin
            push_st(pc + 1, 0, $sformatf("retry%0d", k), 24'h34107C, 4'd4, 1'b0, 1'b0, 1'b1);
            pulse_a(1'b1);
        end
        push_st(pc + 1, 0, "retry_err", 24'h34107C, 4'd4, 1'b0, 1'b1, 1'b0);
        pulse_a(1'b1);
        push_st(pc + 1, 0, "err_hold", 24'h34107C, 4'd4, 1'b0, 1'b1, 1'b0);
        pulse_a(1'b0);
        push_st(pc + 1, 0, "err_key", 24'h341200, 4'd0, 1'b0, 1'b0, 1'b1);
        key = 1'b1;
        step();
        key = 1'b0;
        for (int k = 0; k < 6; k++) begin
            push_st(pc + 1, 0, $sformatf("walk%0d", k), seq_m[k+1], 4'(k + 1), 1'b0, 1'b0, 1'b1);
            pulse_a(1'b0);
        end
`else
        push_st(pc + 1, 0, "nack_adv", 24'h34007F, 4'd5, 1'b0, 1'b0, 1'b1);
        pulse_a(1'b1);
        push_st(pc + 1, 0, "walk6", 24'h34027F, 4'd6, 1'b0, 1'b0, 1'b1);
        pulse_a(1'b0);
`endif

        // Restart wins over a simultaneous NEXT_WORD at idx 6.
        push_st(pc + 1, 0, "key_vs_nw", 24'h341200, 4'd0, 1'b0, 1'b0, 1'b1);
        key = 1'b1;
        bus_a.NEXT_WORD = 1'b1;
        step();
        key = 1'b0;
        bus_a.NEXT_WORD = 1'b0;
        push_st(pc + 1, 0, "after_key", 24'h340C00, 4'd1, 1'b0, 1'b0, 1'b1);
        pulse_a(1'b0);

        repeat (3) step();
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL %s: got unchecked, expected check at cycle %0d", e.name, e.at);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/codec_cfg_sequencer.md
# codec_cfg_sequencer

Parametrised successor to the fixed codec configuration sequencer. It generates the I2C bit-phase enables from CLOCK31_5 and steps through a register-write table for the audio codec. It presents one 24-bit word (slave address, register, data) at a time to the I2C shifter. Beyond the fixed sequencer it adds:
- parametrised timing, depth and slave address;
- restart on KEY0_EDGE or on a microphone/line-in mode change;
- done/error status;
- an optional NACK retry.

## Interface
Parameters:
- CLK_DIV, 2048: bit-period length in CLOCK31_5 cycles (counter wraps at CLK_DIV-1).
- SCL_HI_START, 800: first counter value at which CLOCK_500 goes high.
- SCL_HI_END, 1820: first counter value at which CLOCK_500 goes low again.
- SDA_START, 450: start of the SDA phase window.
- SDA_END, 1990: end of the SDA phase window (exclusive).
- N_WORDS, 11: table length, legal range 2..11.
- SLAVE_ADDR, 8'h34: I2C write address placed in DATA[23:16].
- MAX_RETRY, 3: NACK retries per word (used only with the macro).

Ports (reset rst_n, asynchronous, active-low; clock CLOCK31_5):
- CLOCK31_5  in  1  system clock, 31.5 MHz
- rst_n  in  1  asynchronous active-low reset
- NEXT_WORD  in  1  one-cycle pulse from the shifter: current word finished
- ACK_ERR  in  1  sampled with NEXT_WORD; 1 = word was NACKed
- KEY0_EDGE  in  1  one-cycle restart pulse
- MICROPHON_ON  in  1  asynchronous switch; 1 = microphone input, 0 = line-in
- DATA  out  24  {SLAVE_ADDR, table word}
- TRANSACTION_REQ  out  1  high while the sequence is running
- CLOCK_500  out  1  SCL phase clock
- CLOCK_500_ena  out  1  one-cycle pulse on each CLOCK_500 rise
- CLOCK_SDAT_ena  out  1  one-cycle pulse on each SDA-window rise
- CFG_DONE  out  1  all words written
- CFG_ERR  out  1  retries exhausted
- WORD_IDX  out  4  current table index

## Operation
Phase generator:
- cnt runs 0..CLK_DIV-1 and wraps.
- CLOCK_500 is registered: it is 1 when SCL_HI_START ≤ cnt < SCL_HI_END.
- sdat is registered: it is 1 when SDA_START ≤ cnt < SDA_END.
- CLOCK_500_ena = CLOCK_500 & ~CLOCK_500_d (combinational from registers).
- CLOCK_SDAT_ena is registered: sdat & ~sdat_d.

Table:
- Index i < N_WORDS-1 returns default entry i from this list: 1200, 0C00, 0E42, 08xx, 107C, 007F, 027F, 047F, 067F, 0A01.
- Index N_WORDS-1 always returns 1201 (activate).
- Smaller N_WORDS truncates the list; the activate word is always last.
- Entry 3 is 0814 when mic_cfg=1 and 0810 when mic_cfg=0.
- DATA is combinational from idx and mic_cfg.

Mode tracking:
- MICROPHON_ON passes through a 2-flop synchroniser (sync2).
- mic_cfg holds the mode applied at the last (re)start.

States:
- RUN: TRANSACTION_REQ=1.
  - NEXT_WORD & ~ACK_ERR: idx++ and retry cleared; if idx was N_WORDS-1, go to DONE.
  - NEXT_WORD & ACK_ERR: handled per Configuration.
- DONE: CFG_DONE=1, TRANSACTION_REQ=0, idx held.
- ERROR: CFG_ERR=1, TRANSACTION_REQ=0, idx held at the failing word.

Restart:
- Triggered by KEY0_EDGE, or by sync2 ≠ mic_cfg, in any state.
- Next cycle: idx=0, retry=0, state=RUN, mic_cfg=sync2.
- Restart has priority over a simultaneous NEXT_WORD.

## Timing
- Reset values:
  - cnt, CLOCK_500, CLOCK_500_ena, CLOCK_SDAT_ena, CFG_DONE, CFG_ERR, idx, retry, sync flops and mic_cfg are all 0.
  - State is RUN, so TRANSACTION_REQ=1.
  - DATA=34_1200.
- idx, and therefore DATA and WORD_IDX, change one cycle after NEXT_WORD.
- CLOCK_500 rises in the cycle after cnt becomes SCL_HI_START. CLOCK_500_ena is high in that same cycle.
- CLOCK_SDAT_ena is high one cycle after sdat rises.
- A MICROPHON_ON change restarts the sequence 3 cycles after the change. If MICROPHON_ON=1 is held through reset, a restart occurs 3 cycles after reset release; this is benign because idx is already 0.
- If reset is asserted mid-word, all state clears immediately and the shifter is reset by the same rst_n.
- All phase windows must satisfy START < END ≤ CLK_DIV; a violating configuration is a fatal elaboration check.

## Configuration
Macro: CODEC_CFG_RETRY_EN.
- Defined:
  - NEXT_WORD & ACK_ERR with retry < MAX_RETRY: retry++ and idx holds, so the same word is resent.
  - NEXT_WORD & ACK_ERR with retry == MAX_RETRY: go to ERROR.
- Undefined:
  - ACK_ERR is ignored; every NEXT_WORD advances idx.
  - ERROR is unreachable and CFG_ERR is tied to 0.

## Test plan
- Reset, then pulse NEXT_WORD 11 times with ACK_ERR=0 → DATA sequence 341200, 340C00, …, 341201; CFG_DONE=1 and TRANSACTION_REQ=0 after the 11th pulse.
- Free-run 4096 cycles → CLOCK_500 high for exactly 1020 cycles per 2048-cycle period; CLOCK_500_ena and CLOCK_SDAT_ena each pulse once per period, 1 cycle wide.
- Reach DONE, then toggle MICROPHON_ON 0→1 → restart within 3 cycles; idx=0; word 3 reads 340814.
- CODEC_CFG_RETRY_EN defined, ACK_ERR=1 on word 4 four times → idx stays 4 for three pulses, then CFG_ERR=1 and TRANSACTION_REQ=0; with the macro undefined, idx advances to 5.
- KEY0_EDGE in the same cycle as NEXT_WORD at idx=6 → idx=0 on the next cycle.
- N_WORDS=4 → sequence 341200, 340C00, 340E42, 341201, then CFG_DONE=1.
